mem_access_ctrl: RTL and testbench

- Sequences MEM-stage data-memory accesses for the pipelined MIPS datapath.
- Decodes the Control unit's 2-bit MemRead/MemWrite codes: 00 none, 01 word, 10 byte, 11 half.
- Drives a req/ack data-memory port with byte enables and lane-replicated write data.
- Stalls the pipeline until the access completes, and sign-extends lb/lh results for write-back.

---
 rtl/mem_access_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: decodes lw/lb/lh/sw/sb/sh, runs a req/ack
// handshake with byte enables, stalls the pipeline and sign-extends sub-word loads.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Misalign,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [1:0] KIND_WORD = 2'b01;
  localparam logic [1:0] KIND_BYTE = 2'b10;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  kind_q, kind_d;
  logic [1:0]  off_q, off_d;
  logic        load_q, load_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] read_data_q, read_data_d;

  logic        valid, illegal, aligned, launch, reject, timeout;
  logic [1:0]  kind;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rd_shift, rd_ext;
  logic [15:0] rd_half;

  // Access decode, byte-enable generation and store-data replication.
  always_comb begin
    valid   = (MemRead != 2'b00) || (MemWrite != 2'b00);
    illegal = (MemRead != 2'b00) && (MemWrite != 2'b00);
    kind    = (MemRead != 2'b00) ? MemRead : MemWrite;
    aligned = 1'b1;
    be      = 4'b1111;
    wdata   = WriteData;
    case (kind)
      KIND_WORD: aligned = (Addr[1:0] == 2'b00);
      KIND_BYTE: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{WriteData[7:0]}};
      end
      2'b11: begin
        aligned = ~Addr[0];
        be      = Addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
    launch  = valid && !illegal && aligned;
    reject  = valid && !launch;
    timeout = (cnt_q == CNT_LAST);
  end

  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (kind_q)
      KIND_BYTE: rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b11:     rd_ext = {{16{rd_half[15]}}, rd_half};
      default:   rd_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Ack beats a coincident timeout because it is tested first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch)      state_d = REQ;
        else if (reject) state_d = ERR;
      end
      REQ: begin
        if (mem_ack)      state_d = DONE;
        else if (timeout) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    kind_d      = kind_q;
    off_d       = off_q;
    load_d      = load_q;
    bus_err_d   = bus_err_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          cnt_d       = 16'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = (MemWrite != 2'b00);
          mem_be_d    = be;
          mem_addr_d  = {Addr[31:2], 2'b00};
          mem_wdata_d = wdata;
          kind_d      = kind;
          off_d       = Addr[1:0];
          load_d      = (MemWrite == 2'b00);
        end else if (reject) begin
          bus_err_d = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (load_q) read_data_d = rd_ext;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 16'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      kind_q      <= 2'b00;
      off_q       <= 2'b00;
      load_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      kind_q      <= kind_d;
      off_q       <= off_d;
      load_q      <= load_d;
      bus_err_q   <= bus_err_d;
      read_data_q <= read_data_d;
    end
  end

  // Launch stall is combinational; gating with rst_n keeps it low during reset.
  always_comb begin
    Stall    = (state_q == REQ) || ((state_q == IDLE) && launch && rst_n);
    Misalign = (state_q == ERR) && !bus_err_q;
    BusErr   = (state_q == ERR) && bus_err_q;
  end

  assign ReadData  = read_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of load/store vectors plus hand-written
// timeout, idle-ack and mid-request reset sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  MemRead, MemWrite;
  logic [31:0] Addr, WriteData, ReadData, mem_addr, mem_wdata, mem_rdata;
  logic        Stall, Misalign, BusErr, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    string       name;
    logic [1:0]  mr, mw;
    logic [31:0] addr, wd, rdata;
    int          ack_dly;
    logic        legal, we;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata, rd;
  } vec_t;

  vec_t vecs[12];

  mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Misalign(Misalign),
    .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    MemRead   = v.mr;
    MemWrite  = v.mw;
    Addr      = v.addr;
    WriteData = v.wd;
    mem_ack   = 1'b0;
    @(negedge clk);
    checkOutput({v.name, ".stall_launch"}, 32'(Stall), 32'(v.legal));
    checkOutput({v.name, ".req_idle"}, 32'(mem_req), 32'd0);
    nextCycle();
    if (v.legal) begin
      for (int k = 0; k <= v.ack_dly; k++) begin
        if (k == v.ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_rdata = 32'h0BAD_0BAD;
        end
        @(negedge clk);
        checkOutput({v.name, ".req"}, 32'(mem_req), 32'd1);
        checkOutput({v.name, ".stall_req"}, 32'(Stall), 32'd1);
        checkOutput({v.name, ".we"}, 32'(mem_we), 32'(v.we));
        checkOutput({v.name, ".be"}, 32'(mem_be), 32'(v.be));
        checkOutput({v.name, ".addr"}, mem_addr, v.maddr);
        checkOutput({v.name, ".wdata"}, mem_wdata, v.mwdata);
        nextCycle();
        mem_ack = 1'b0;
      end
      MemRead  = 2'b00;
      MemWrite = 2'b00;
      @(negedge clk);
      checkOutput({v.name, ".stall_done"}, 32'(Stall), 32'd0);
      checkOutput({v.name, ".req_done"}, 32'(mem_req), 32'd0);
      checkOutput({v.name, ".buserr_done"}, 32'(BusErr), 32'd0);
      checkOutput({v.name, ".rdata"}, ReadData, v.rd);
      nextCycle();
    end else begin
      MemRead  = 2'b00;
      MemWrite = 2'b00;
      @(negedge clk);
      checkOutput({v.name, ".misalign"}, 32'(Misalign), 32'd1);
      checkOutput({v.name, ".buserr"}, 32'(BusErr), 32'd0);
      checkOutput({v.name, ".req_err"}, 32'(mem_req), 32'd0);
      checkOutput({v.name, ".stall_err"}, 32'(Stall), 32'd0);
      checkOutput({v.name, ".rdata_err"}, ReadData, v.rd);
      nextCycle();
      @(negedge clk);
      checkOutput({v.name, ".misalign_pulse"}, 32'(Misalign), 32'd0);
      nextCycle();
    end
  endtask

  initial begin
    vec_t v;
    //            name       mr     mw     addr          wd            rdata        dly legal we be       maddr         mwdata        rd
    vecs[0]  = '{"lw10",   2'b01, 2'b00, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{"lb13",   2'b10, 2'b00, 32'h0000_0013, 32'h0,        32'h8022_3344, 0, 1'b1, 1'b0, 4'b1000, 32'h10, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{"lh12",   2'b11, 2'b00, 32'h0000_0012, 32'h0,        32'h8022_3344, 0, 1'b1, 1'b0, 4'b1100, 32'h10, 32'h0,        32'hFFFF_8022};
    vecs[3]  = '{"lb11",   2'b10, 2'b00, 32'h0000_0011, 32'h0,        32'h8022_3344, 2, 1'b1, 1'b0, 4'b0010, 32'h10, 32'h0,        32'h0000_0033};
    vecs[4]  = '{"lh10",   2'b11, 2'b00, 32'h0000_0010, 32'h0,        32'h1234_F00D, 0, 1'b1, 1'b0, 4'b0011, 32'h10, 32'h0,        32'hFFFF_F00D};
    vecs[5]  = '{"sb21",   2'b00, 2'b10, 32'h0000_0021, 32'h0000_00A5, 32'h5555_5555, 0, 1'b1, 1'b1, 4'b0010, 32'h20, 32'hA5A5_A5A5, 32'hFFFF_F00D};
    vecs[6]  = '{"sh22",   2'b00, 2'b11, 32'h0000_0022, 32'h0000_1234, 32'h5555_5555, 1, 1'b1, 1'b1, 4'b1100, 32'h20, 32'h1234_1234, 32'hFFFF_F00D};
    vecs[7]  = '{"sw44",   2'b00, 2'b01, 32'h0000_0044, 32'hCAFE_F00D, 32'h5555_5555, 0, 1'b1, 1'b1, 4'b1111, 32'h44, 32'hCAFE_F00D, 32'hFFFF_F00D};
    vecs[8]  = '{"lw02",   2'b01, 2'b00, 32'h0000_0002, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,  32'h0,        32'hFFFF_F00D};
    vecs[9]  = '{"lwsw",   2'b01, 2'b01, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,  32'h0,        32'hFFFF_F00D};
    vecs[10] = '{"sh01",   2'b00, 2'b11, 32'h0000_0001, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,  32'h0,        32'hFFFF_F00D};
    vecs[11] = '{"lwtmo",  2'b01, 2'b00, 32'h0000_0100, 32'h0,        32'h7FFF_FFFF, 3, 1'b1, 1'b0, 4'b1111, 32'h100, 32'h0,       32'h7FFF_FFFF};

    rst_n = 1'b0; MemRead = 2'b00; MemWrite = 2'b00; Addr = 32'h0; WriteData = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    #12;
    checkOutput("rst.req", 32'(mem_req), 32'd0);
    checkOutput("rst.we", 32'(mem_we), 32'd0);
    checkOutput("rst.be", 32'(mem_be), 32'd0);
    checkOutput("rst.addr", mem_addr, 32'd0);
    checkOutput("rst.wdata", mem_wdata, 32'd0);
    checkOutput("rst.rdata", ReadData, 32'd0);
    checkOutput("rst.misalign", 32'(Misalign), 32'd0);
    checkOutput("rst.buserr", 32'(BusErr), 32'd0);
    checkOutput("rst.stall", 32'(Stall), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Ack timeout: four REQ cycles then a BusErr pulse with ReadData untouched.
    MemRead = 2'b01; Addr = 32'h0000_0200;
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("tmo.req", 32'(mem_req), 32'd1);
      checkOutput("tmo.stall", 32'(Stall), 32'd1);
      nextCycle();
    end
    MemRead = 2'b00;
    @(negedge clk);
    checkOutput("tmo.buserr", 32'(BusErr), 32'd1);
    checkOutput("tmo.misalign", 32'(Misalign), 32'd0);
    checkOutput("tmo.req_drop", 32'(mem_req), 32'd0);
    checkOutput("tmo.stall_err", 32'(Stall), 32'd0);
    checkOutput("tmo.rdata", ReadData, 32'h7FFF_FFFF);
    nextCycle();
    @(negedge clk);
    checkOutput("tmo.buserr_pulse", 32'(BusErr), 32'd0);
    nextCycle();

    // A stray ack with no request outstanding must not load data.
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    checkOutput("idleack.stall", 32'(Stall), 32'd0);
    nextCycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("idleack.rdata", ReadData, 32'h7FFF_FFFF);
    checkOutput("idleack.req", 32'(mem_req), 32'd0);
    nextCycle();

    // Reset in the middle of a request, then a late ack, then a clean lw.
    MemRead = 2'b01; Addr = 32'h0000_0300;
    nextCycle();
    checkOutput("rstreq.req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstreq.req_async", 32'(mem_req), 32'd0);
    checkOutput("rstreq.stall_async", 32'(Stall), 32'd0);
    checkOutput("rstreq.rdata_async", ReadData, 32'd0);
    MemRead = 2'b00;
    nextCycle();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
    nextCycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("rstreq.late_ack_rdata", ReadData, 32'd0);
    checkOutput("rstreq.late_ack_req", 32'(mem_req), 32'd0);
    nextCycle();
    v = '{"lwpost", 2'b01, 2'b00, 32'h0000_0010, 32'h0, 32'h1357_2468, 0, 1'b1, 1'b0,
          4'b1111, 32'h10, 32'h0, 32'h1357_2468};
    applyStimulus(v);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
